// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Shares one write-port / async-read-port memory between two requesters.
//   After reset, or when asked to, it clears every word to clear_value.
//   It then grants at most one request per cycle, round-robin.
//   Read data comes back one cycle after the grant, through a register.
//
// Ports
//   clk, arst_n             clock, asynchronous active-low reset
//   clear                   one-cycle pulse; starts a clear (only in SERVE)
//   init_done               high while serving requests
//   reqN_valid/ready        request handshake, transfer on valid & ready
//   reqN_wen/addr/wdata     request kind (1 = write), address, write data
//   respN_valid/rdata       one-cycle read response, data held afterwards
//   mem_wen/waddr/wdata     memory write port
//   mem_raddr, mem_rdata    memory async read port
module mem_rr_arbiter #(
  parameter int               width       = 16,
  parameter int               depth       = 16,
  parameter logic [width-1:0] clear_value = '0
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     clear,
  output logic                     init_done,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_wen,
  input  logic [$clog2(depth)-1:0] req0_addr,
  input  logic [width-1:0]         req0_wdata,
  output logic                     resp0_valid,
  output logic [width-1:0]         resp0_rdata,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_wen,
  input  logic [$clog2(depth)-1:0] req1_addr,
  input  logic [width-1:0]         req1_wdata,
  output logic                     resp1_valid,
  output logic [width-1:0]         resp1_rdata,
  output logic                     mem_wen,
  output logic [$clog2(depth)-1:0] mem_waddr,
  output logic [width-1:0]         mem_wdata,
  output logic [$clog2(depth)-1:0] mem_raddr,
  input  logic [width-1:0]         mem_rdata
);

  localparam int aw = $clog2(depth);
  localparam logic [aw-1:0] last_addr = aw'(depth - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t          state;
  logic [aw-1:0]   clr_addr;
  logic            prio;
  logic            serving;
  logic            grant0;
  logic            grant1;

  // A clear pulse blocks every grant in its own cycle, so the switch to
  // CLEAR never races with a transfer the clients believe has completed.
  always_comb begin
    serving = (state == SERVE) && !clear;
    grant0  = serving && req0_valid && (!req1_valid || !prio);
    grant1  = serving && req1_valid && (!req0_valid ||  prio);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign init_done  = (state == SERVE);

  // Idle values are forced to zero so the memory bus is quiet and
  // deterministic whenever no write or read is granted.
  always_comb begin
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (state == CLEAR) begin
      mem_wen   = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = clear_value;
    end else if (grant0) begin
      if (req0_wen) begin
        mem_wen   = 1'b1;
        mem_waddr = req0_addr;
        mem_wdata = req0_wdata;
      end else begin
        mem_raddr = req0_addr;
      end
    end else if (grant1) begin
      if (req1_wen) begin
        mem_wen   = 1'b1;
        mem_waddr = req1_addr;
        mem_wdata = req1_wdata;
      end else begin
        mem_raddr = req1_addr;
      end
    end
  end

  // Controller state, clear address, round-robin pointer.
  // clr_addr wraps back to 0 by itself because depth is a power of two.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      prio     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + aw'(1);
          if (clr_addr == last_addr) begin
            state <= SERVE;
          end
        end
        SERVE: begin
          if (clear) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
          if (grant0) begin
            prio <= 1'b1;
          end else if (grant1) begin
            prio <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Read responses: the async read data is captured at the grant edge, so
  // the response appears one cycle later. rdata holds between responses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      resp0_valid <= 1'b0;
      resp0_rdata <= '0;
      resp1_valid <= 1'b0;
      resp1_rdata <= '0;
    end else begin
      resp0_valid <= grant0 && !req0_wen;
      resp1_valid <= grant1 && !req1_wen;
      if (grant0 && !req0_wen) begin
        resp0_rdata <= mem_rdata;
      end
      if (grant1 && !req1_wen) begin
        resp1_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
//   Directed bench for mem_rr_arbiter (depth 16, width 16, clear value A5A5)
//   with a behavioural model of the shared memory attached.
module tb_mem_rr_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        clear;
  logic        init_done;
  logic        req0_valid, req0_ready, req0_wen;
  logic [3:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        resp0_valid;
  logic [15:0] resp0_rdata;
  logic        req1_valid, req1_ready, req1_wen;
  logic [3:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        resp1_valid;
  logic [15:0] resp1_rdata;
  logic        mem_wen;
  logic [3:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic [3:0]  mem_raddr;
  logic [15:0] mem_rdata;

  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(
    .width(16),
    .depth(16),
    .clear_value(16'hA5A5)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .clear(clear),
    .init_done(init_done),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_wen(req0_wen),
    .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_wen(req1_wen),
    .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata),
    .mem_wen(mem_wen),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous write, asynchronous read, non-cleared contents
  // start as a recognisable pattern so a missing clear shows up.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0F00 + 16'(i);
  end
  always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  // Drive one cycle of inputs just after the falling edge; outputs are
  // sampled 1 time unit later, well away from the rising edge.
  task automatic applyStimulus(input logic v0, input logic w0, input logic [3:0] a0,
                               input logic [15:0] d0, input logic v1, input logic w1,
                               input logic [3:0] a1, input logic [15:0] d1,
                               input logic clr);
    @(negedge clk);
    req0_valid = v0; req0_wen = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_wen = w1; req1_addr = a1; req1_wdata = d1;
    clear = clr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkClearCycle(input int k);
    checkOutput("clr_wen", 32'(mem_wen), 32'd1);
    checkOutput("clr_waddr", 32'(mem_waddr), 32'(k));
    checkOutput("clr_wdata", 32'(mem_wdata), 32'hA5A5);
    checkOutput("clr_ready0", 32'(req0_ready), 32'd0);
    checkOutput("clr_ready1", 32'(req1_ready), 32'd0);
    checkOutput("clr_init_done", 32'(init_done), 32'd0);
    checkOutput("clr_resp0_valid", 32'(resp0_valid), 32'd0);
    checkOutput("clr_resp1_valid", 32'(resp1_valid), 32'd0);
  endtask

  initial begin
    clear = 0;
    req0_valid = 0; req0_wen = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_wen = 0; req1_addr = 0; req1_wdata = 0;
    arst_n = 1'b1;
    #2 arst_n = 1'b0;
    #2;
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
    checkOutput("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    checkOutput("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    checkOutput("rst_resp0_rdata", 32'(resp0_rdata), 32'd0);
    checkOutput("rst_resp1_rdata", 32'(resp1_rdata), 32'd0);
    @(posedge clk);
    #2 arst_n = 1'b1;

    // Initial clear, req0 already waiting to read addr 7; a clear pulse in
    // the middle must be ignored.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 0, 4'd7, 16'h0, 0, 0, 4'd0, 16'h0, k == 8);
      checkClearCycle(k);
    end
    applyStimulus(1, 0, 4'd7, 16'h0, 0, 0, 4'd0, 16'h0, 0);
    checkOutput("serve_init_done", 32'(init_done), 32'd1);
    checkOutput("rd7_ready0", 32'(req0_ready), 32'd1);
    checkOutput("rd7_ready1", 32'(req1_ready), 32'd0);
    checkOutput("rd7_raddr", 32'(mem_raddr), 32'd7);
    checkOutput("rd7_wen", 32'(mem_wen), 32'd0);

    // req0 write 1234 to addr 3, then read it back.
    applyStimulus(1, 1, 4'd3, 16'h1234, 0, 0, 4'd0, 16'h0, 0);
    checkOutput("rd7_resp0_valid", 32'(resp0_valid), 32'd1);
    checkOutput("rd7_resp0_rdata", 32'(resp0_rdata), 32'hA5A5);
    checkOutput("rd7_resp1_valid", 32'(resp1_valid), 32'd0);
    checkOutput("wr3_ready0", 32'(req0_ready), 32'd1);
    checkOutput("wr3_wen", 32'(mem_wen), 32'd1);
    checkOutput("wr3_waddr", 32'(mem_waddr), 32'd3);
    checkOutput("wr3_wdata", 32'(mem_wdata), 32'h1234);
    checkOutput("wr3_raddr_idle", 32'(mem_raddr), 32'd0);
    applyStimulus(1, 0, 4'd3, 16'h0, 0, 0, 4'd0, 16'h0, 0);
    checkOutput("rd3_ready0", 32'(req0_ready), 32'd1);
    checkOutput("rd3_raddr", 32'(mem_raddr), 32'd3);
    checkOutput("rd3_wen_idle", 32'(mem_wen), 32'd0);
    checkOutput("rd3_waddr_idle", 32'(mem_waddr), 32'd0);
    checkOutput("rd3_wdata_idle", 32'(mem_wdata), 32'd0);
    checkOutput("wr3_no_resp", 32'(resp0_valid), 32'd0);

    // req1 alone for three cycles: write 5, read 5, read 3.
    applyStimulus(0, 0, 4'd0, 16'h0, 1, 1, 4'd5, 16'hBEEF, 0);
    checkOutput("raw_resp0_valid", 32'(resp0_valid), 32'd1);
    checkOutput("raw_resp0_rdata", 32'(resp0_rdata), 32'h1234);
    checkOutput("raw_resp1_valid", 32'(resp1_valid), 32'd0);
    checkOutput("wr5_ready1", 32'(req1_ready), 32'd1);
    checkOutput("wr5_ready0", 32'(req0_ready), 32'd0);
    checkOutput("wr5_waddr", 32'(mem_waddr), 32'd5);
    checkOutput("wr5_wdata", 32'(mem_wdata), 32'hBEEF);
    applyStimulus(0, 0, 4'd0, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("rd5_ready1", 32'(req1_ready), 32'd1);
    checkOutput("rd5_raddr", 32'(mem_raddr), 32'd5);
    checkOutput("hold_resp0_valid", 32'(resp0_valid), 32'd0);
    checkOutput("hold_resp0_rdata", 32'(resp0_rdata), 32'h1234);
    applyStimulus(0, 0, 4'd0, 16'h0, 1, 0, 4'd3, 16'h0, 0);
    checkOutput("rd3b_ready1", 32'(req1_ready), 32'd1);
    checkOutput("rd3b_raddr", 32'(mem_raddr), 32'd3);
    checkOutput("rd5_resp1_valid", 32'(resp1_valid), 32'd1);
    checkOutput("rd5_resp1_rdata", 32'(resp1_rdata), 32'hBEEF);

    // Both read for four cycles: grants alternate 0,1,0,1.
    applyStimulus(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("rr1_ready0", 32'(req0_ready), 32'd1);
    checkOutput("rr1_ready1", 32'(req1_ready), 32'd0);
    checkOutput("rr1_raddr", 32'(mem_raddr), 32'd3);
    checkOutput("b2b_resp1_valid", 32'(resp1_valid), 32'd1);
    checkOutput("b2b_resp1_rdata", 32'(resp1_rdata), 32'h1234);
    applyStimulus(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("rr2_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rr2_ready1", 32'(req1_ready), 32'd1);
    checkOutput("rr2_raddr", 32'(mem_raddr), 32'd5);
    checkOutput("rr2_resp0_valid", 32'(resp0_valid), 32'd1);
    checkOutput("rr2_resp0_rdata", 32'(resp0_rdata), 32'h1234);
    checkOutput("rr2_resp1_valid", 32'(resp1_valid), 32'd0);
    applyStimulus(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("rr3_ready0", 32'(req0_ready), 32'd1);
    checkOutput("rr3_ready1", 32'(req1_ready), 32'd0);
    checkOutput("rr3_resp1_valid", 32'(resp1_valid), 32'd1);
    checkOutput("rr3_resp1_rdata", 32'(resp1_rdata), 32'hBEEF);
    checkOutput("rr3_resp0_valid", 32'(resp0_valid), 32'd0);
    applyStimulus(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("rr4_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rr4_ready1", 32'(req1_ready), 32'd1);
    checkOutput("rr4_resp0_valid", 32'(resp0_valid), 32'd1);
    checkOutput("rr4_resp0_rdata", 32'(resp0_rdata), 32'h1234);
    applyStimulus(0, 0, 4'd0, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("solo_ready1", 32'(req1_ready), 32'd1);
    checkOutput("rr4_resp1_rdata", 32'(resp1_rdata), 32'hBEEF);

    // Clear while both valid: no grant, scheduled response still completes.
    applyStimulus(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 1);
    checkOutput("clrq_ready0", 32'(req0_ready), 32'd0);
    checkOutput("clrq_ready1", 32'(req1_ready), 32'd0);
    checkOutput("clrq_wen", 32'(mem_wen), 32'd0);
    checkOutput("clrq_raddr", 32'(mem_raddr), 32'd0);
    checkOutput("clrq_init_done", 32'(init_done), 32'd1);
    checkOutput("clrq_resp1_valid", 32'(resp1_valid), 32'd1);
    checkOutput("clrq_resp1_rdata", 32'(resp1_rdata), 32'hBEEF);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);
      checkClearCycle(k);
    end
    applyStimulus(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("post_clr_init_done", 32'(init_done), 32'd1);
    checkOutput("post_clr_ready0", 32'(req0_ready), 32'd1);
    checkOutput("post_clr_ready1", 32'(req1_ready), 32'd0);
    checkOutput("post_clr_raddr", 32'(mem_raddr), 32'd3);
    applyStimulus(0, 0, 4'd0, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    checkOutput("post_clr_ready1b", 32'(req1_ready), 32'd1);
    checkOutput("cleared3_valid", 32'(resp0_valid), 32'd1);
    checkOutput("cleared3_rdata", 32'(resp0_rdata), 32'hA5A5);
    applyStimulus(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, 0);
    checkOutput("cleared5_valid", 32'(resp1_valid), 32'd1);
    checkOutput("cleared5_rdata", 32'(resp1_rdata), 32'hA5A5);
    checkOutput("idle_ready0", 32'(req0_ready), 32'd0);

    // Reset on the 5th clear cycle, then a full restarted clear.
    applyStimulus(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, 1);
    checkOutput("clr2_init_done", 32'(init_done), 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, 0);
      checkClearCycle(k);
    end
    @(negedge clk);
    arst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    checkOutput("arst_init_done", 32'(init_done), 32'd0);
    checkOutput("arst_ready0", 32'(req0_ready), 32'd0);
    checkOutput("arst_resp0_valid", 32'(resp0_valid), 32'd0);
    checkOutput("arst_resp0_rdata", 32'(resp0_rdata), 32'd0);
    checkOutput("arst_resp1_rdata", 32'(resp1_rdata), 32'd0);
    checkOutput("arst_clr_addr", 32'(mem_waddr), 32'd0);
    @(posedge clk);
    #2 arst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, 0);
      checkClearCycle(k);
    end
    applyStimulus(1, 0, 4'd4, 16'h0, 1, 0, 4'd9, 16'h0, 0);
    checkOutput("rst2_init_done", 32'(init_done), 32'd1);
    checkOutput("rst2_ready0", 32'(req0_ready), 32'd1);
    checkOutput("rst2_ready1", 32'(req1_ready), 32'd0);
    applyStimulus(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, 0);
    checkOutput("rst2_resp0_valid", 32'(resp0_valid), 32'd1);
    checkOutput("rst2_resp0_rdata", 32'(resp0_rdata), 32'hA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Controller sharing one coreir_mem instance between two requesters.
- The memory has one write port and one asynchronous read port.
- After reset, or on request, it sequences a clear of the whole array.
- It then grants one request per cycle by round-robin and returns registered read data.
- Sits between the memory wrapper and two client datapaths.

Parameters:
- width, 16, data width in bits; must match the memory width.
- depth, 16, number of memory words; power of two, at least 2.
- clear_value, 0, width-bit value written to every word during a clear.

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  asynchronous active-low reset.
- clear  in  1  single-cycle pulse that starts a clear sequence; honoured only in SERVE.
- init_done  out  1  high while in SERVE.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 is granted this cycle.
- req0_wen  in  1  1 = write request, 0 = read request.
- req0_addr  in  $clog2(depth)  word address.
- req0_wdata  in  width  write data.
- resp0_valid  out  1  read data valid.
- resp0_rdata  out  width  read data.
- req1_valid, req1_ready, req1_wen, req1_addr, req1_wdata, resp1_valid, resp1_rdata: same as requester 0, for requester 1.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  $clog2(depth)  memory write address.
- mem_wdata  out  width  memory write data.
- mem_raddr  out  $clog2(depth)  memory read address.
- mem_rdata  in  width  memory read data; combinational from mem_raddr.

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=CLEAR, clr_addr=0, prio=0 (requester 0 favoured first).
  - init_done=0.
  - resp*_valid=0, resp*_rdata=0.
  - All ready outputs are 0.
- Reset asserted mid-CLEAR or mid-SERVE aborts the current operation; CLEAR restarts from address 0.
- CLEAR state:
  - Each cycle drives mem_wen=1, mem_waddr=clr_addr, mem_wdata=clear_value; clr_addr increments.
  - After the cycle with clr_addr==depth-1, moves to SERVE and clr_addr wraps to 0.
  - Takes exactly depth cycles; init_done rises on the following cycle.
  - req*_ready=0 throughout; clear input ignored; resp*_valid=0.
- SERVE state, grant logic (combinational from valid inputs):
  - Only one valid: that requester is granted.
  - Both valid: requester prio is granted.
  - Neither valid: no grant.
- SERVE state, outputs:
  - req_i_ready = grant_i.
  - The transfer completes in the same cycle (valid & ready).
- prio update: on any grant to i, prio <= 1-i; no grant leaves prio unchanged.
- Granted write:
  - mem_wen=1, mem_waddr=req_i_addr, mem_wdata=req_i_wdata in the same cycle.
  - No response is generated.
- Granted read:
  - mem_raddr=req_i_addr.
  - Next cycle: resp_i_valid=1 for exactly one cycle, resp_i_rdata = mem_rdata sampled at the grant edge.
  - Read latency is 1 cycle.
  - resp_i_rdata holds its last value while resp_i_valid=0.
- Idle values:
  - When there is no write grant, mem_wen=0; mem_waddr and mem_wdata are 0.
  - When there is no read grant, mem_raddr=0.
- Read-after-write: a write accepted in cycle N is visible to a read granted in cycle N+1.
- Clear request:
  - clear=1 in SERVE suppresses all grants that cycle.
  - Next state is CLEAR with clr_addr=0 and init_done=0 from the next cycle.
  - A read response already scheduled from the previous cycle still completes.
  - prio is not reset by clear.
- Back-to-back reads to the same requester are allowed every cycle, and resp_valid stays high continuously.
- No internal queueing: an ungranted requester holds valid and its request fields until ready.
- Address width: $clog2(depth); no out-of-range addresses exist.

Test Plan:
- Reset then idle, depth=16, clear_value=16'hA5A5 -> mem_wen high for 16 cycles at addr 0..15; init_done rises on cycle 17; a read of addr 7 returns 16'hA5A5 one cycle after grant.
- Req0 writes 16'h1234 to addr 3, then req0 reads addr 3 the next cycle -> resp0_valid pulses 1 cycle after read grant with 16'h1234; resp1_valid stays 0.
- Both requesters hold read requests for 4 cycles, prio=0 -> grants alternate 0,1,0,1; each resp_valid pulses on alternate cycles with correct data.
- Only req1 valid for 3 cycles -> granted every cycle; prio ends at 0; a subsequent contended cycle grants requester 0.
- clear pulsed while both valid -> no grant that cycle; init_done falls next cycle; 16 clear writes follow; pending requests are granted only after init_done=1.
- arst_n asserted on the 5th cycle of CLEAR -> outputs return to reset values immediately; after release, the clear restarts at addr 0 and runs a full 16 cycles.
